// File: rtl/icache.sv
// Direct-mapped instruction cache with multi-word lines and an abortable line refill.
//
// Sits between the fetch stage (lookup side) and mem_ctrl (refill side). Lookups are
// combinational and keep working for other lines while a refill is in progress.
//
// Ports:
//   clk, rst      clock; asynchronous active-high reset
//   req_valid     fetch request for req_addr this cycle
//   req_addr      word-aligned fetch address (bits [1:0] ignored)
//   flush         invalidate every line and abort any refill
//   hit, inst     instruction valid this cycle / instruction word (0 on miss)
//   stall         req_valid && !hit
//   mem_req       one-cycle word read request toward mem_ctrl
//   mem_addr      word address of mem_req (0 when idle)
//   mem_busy      mem_ctrl cannot accept a request this cycle
//   mem_rdy       one-cycle pulse, mem_data valid
//   mem_data      returned word
module icache #(
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned LINES      = 64,
  parameter int unsigned LINE_WORDS = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic              flush,
  output logic              hit,
  output logic [31:0]       inst,
  output logic              stall,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_busy,
  input  logic              mem_rdy,
  input  logic [31:0]       mem_data
);

  localparam int unsigned OFF_W = $clog2(LINE_WORDS);
  localparam int unsigned IDX_W = $clog2(LINES);
  // Keep the word counter at least one bit wide so single-word lines still elaborate.
  localparam int unsigned CNT_W = (OFF_W > 0) ? OFF_W : 1;
  localparam int unsigned TAG_W = ADDR_W - 2 - OFF_W - IDX_W;
  localparam logic [ADDR_W-1:0] LINE_MASK = ADDR_W'(LINE_WORDS * 4 - 1);
  localparam logic [ADDR_W-1:0] OFF_MASK  = ADDR_W'(LINE_WORDS - 1);
  localparam logic [CNT_W-1:0]  LAST_CNT  = CNT_W'(LINE_WORDS - 1);

  typedef enum logic [1:0] {StIdle, StIssue, StWait, StDrain} state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [ADDR_W-1:0]   base_q, base_d;

  logic [31:0]         data_q [LINES][LINE_WORDS];
  logic [TAG_W-1:0]    tag_q  [LINES];
  logic [LINES-1:0]    valid_q;

  logic [IDX_W-1:0]    req_idx, fill_idx;
  logic [TAG_W-1:0]    req_tag, fill_tag;
  logic [CNT_W-1:0]    req_off;
  logic                miss_start, fill_we, fill_done;

  assign req_idx  = req_addr[2+OFF_W +: IDX_W];
  assign req_tag  = req_addr[ADDR_W-1 -: TAG_W];
  assign req_off  = CNT_W'((req_addr >> 2) & OFF_MASK);
  assign fill_idx = base_q[2+OFF_W +: IDX_W];
  assign fill_tag = base_q[ADDR_W-1 -: TAG_W];

  // Lookup is independent of the refill FSM, giving hit-under-refill for other lines.
  always_comb begin
    hit   = req_valid && !flush && valid_q[req_idx] && (tag_q[req_idx] == req_tag);
    inst  = hit ? data_q[req_idx][req_off] : 32'h0;
    stall = req_valid && !hit;
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    base_d     = base_q;
    mem_req    = 1'b0;
    mem_addr   = '0;
    miss_start = 1'b0;
    fill_we    = 1'b0;
    fill_done  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (req_valid && !hit && !flush) begin
          base_d     = req_addr & ~LINE_MASK;
          cnt_d      = '0;
          miss_start = 1'b1;
          state_d    = StIssue;
        end
      end
      StIssue: begin
        if (flush) begin
          state_d = StIdle;
        end else if (!mem_busy) begin
          mem_req  = 1'b1;
          mem_addr = base_q + (ADDR_W'(cnt_q) << 2);
          state_d  = StWait;
        end
      end
      StWait: begin
        if (flush) begin
          // A word still in flight must be absorbed before a new refill may issue.
          state_d = mem_rdy ? StIdle : StDrain;
        end else if (mem_rdy) begin
          fill_we = 1'b1;
          if (cnt_q == LAST_CNT) begin
            fill_done = 1'b1;
            state_d   = StIdle;
          end else begin
            cnt_d   = cnt_q + 1'b1;
            state_d = StIssue;
          end
        end
      end
      StDrain: begin
        if (mem_rdy) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      base_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      base_q  <= base_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= '0;
    end else if (flush) begin
      valid_q <= '0;
    end else begin
      // The line being refilled stays invalid until its last word lands.
      if (miss_start) valid_q[req_idx] <= 1'b0;
      if (fill_done)  valid_q[fill_idx] <= 1'b1;
    end
  end

  // Data and tag arrays are qualified by valid_q, so they need no reset.
  always_ff @(posedge clk) begin
    if (fill_we)   data_q[fill_idx][cnt_q] <= mem_data;
    if (fill_done) tag_q[fill_idx]         <= fill_tag;
  end

endmodule

// File: tb/tb_icache.sv
// Self-checking bench for icache: directed scenarios plus randomized traffic, all
// checked against a transaction-level model of line residency and refill progress.
module tb_icache;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned LINES  = 64;
  localparam int unsigned LW     = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic              req_valid;
  logic [ADDR_W-1:0] req_addr;
  logic              flush;
  logic              hit;
  logic [31:0]       inst;
  logic              stall;
  logic              mem_req;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_busy;
  logic              mem_rdy;
  logic [31:0]       mem_data;

  always #5 clk = ~clk;

  icache #(.ADDR_W(ADDR_W), .LINES(LINES), .LINE_WORDS(LW)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_addr(req_addr), .flush(flush),
    .hit(hit), .inst(inst), .stall(stall), .mem_req(mem_req), .mem_addr(mem_addr),
    .mem_busy(mem_busy), .mem_rdy(mem_rdy), .mem_data(mem_data)
  );

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int req_count = 0;
  int hit_count = 0;

  // memory responder
  bit          pend_on;
  int          pend;
  logic [31:0] pend_addr;
  int          lat = 2;
  bit          rand_lat = 0;

  // reference model: resident lines and the refill in flight
  bit          m_valid [LINES];
  int unsigned m_line  [LINES];
  bit          m_busy, m_out, m_drain;
  int unsigned m_base;
  int          m_words;

  // last sampled outputs
  bit          o_hit, o_req;
  logic [31:0] o_inst, o_addr;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  function automatic int unsigned line_of(input logic [31:0] a);
    return a / (4 * LW);
  endfunction

  function automatic int unsigned idx_of(input logic [31:0] a);
    return line_of(a) % LINES;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < LINES; i++) begin
      m_valid[i] = 1'b0;
      m_line[i]  = 0;
    end
    m_busy = 0; m_out = 0; m_drain = 0; m_base = 0; m_words = 0;
    pend_on = 0; pend = 0;
  endtask

  // One clock cycle: drive responder, check outputs at negedge, advance model.
  task automatic step();
    logic        exp_hit, exp_req;
    logic [31:0] exp_inst, exp_addr;
    int unsigned ri;
    mem_rdy  = 1'b0;
    mem_data = 32'h0;
    if (pend_on) begin
      pend--;
      if (pend == 0) begin
        mem_rdy  = 1'b1;
        mem_data = mem_word(pend_addr);
        pend_on  = 0;
      end
    end
    @(negedge clk);
    ri       = idx_of(req_addr);
    exp_hit  = req_valid && !flush && m_valid[ri] && (m_line[ri] == line_of(req_addr));
    exp_inst = exp_hit ? mem_word(req_addr & ~32'h3) : 32'h0;
    exp_req  = m_busy && !m_drain && !m_out && !mem_busy && !flush;
    exp_addr = exp_req ? m_base + 4 * m_words : 32'h0;
    checks += 5;
    if (hit !== exp_hit) begin
      errors++; $display("FAIL hit cyc=%0d got=%b exp=%b", cyc, hit, exp_hit);
    end
    if (inst !== exp_inst) begin
      errors++; $display("FAIL inst cyc=%0d got=%h exp=%h", cyc, inst, exp_inst);
    end
    if (stall !== (req_valid && !exp_hit)) begin
      errors++; $display("FAIL stall cyc=%0d got=%b exp=%b", cyc, stall, req_valid && !exp_hit);
    end
    if (mem_req !== exp_req) begin
      errors++; $display("FAIL mem_req cyc=%0d got=%b exp=%b", cyc, mem_req, exp_req);
    end
    if (mem_addr !== exp_addr) begin
      errors++; $display("FAIL mem_addr cyc=%0d got=%h exp=%h", cyc, mem_addr, exp_addr);
    end
    o_hit = hit; o_inst = inst; o_req = mem_req; o_addr = mem_addr;
    if (hit) hit_count++;
    if (mem_req) begin
      req_count++;
      pend_on   = 1;
      pend_addr = mem_addr;
      pend      = rand_lat ? int'($urandom_range(1, 3)) : lat;
    end
    // model update for the coming edge
    if (m_drain) begin
      if (mem_rdy) begin m_drain = 0; m_busy = 0; m_out = 0; end
    end else if (m_busy) begin
      if (flush) begin
        if (m_out && !mem_rdy) m_drain = 1;
        else begin m_busy = 0; m_out = 0; end
      end else if (m_out) begin
        if (mem_rdy) begin
          m_out = 0;
          m_words++;
          if (m_words == LW) begin
            m_valid[idx_of(m_base)] = 1;
            m_line[idx_of(m_base)]  = line_of(m_base);
            m_busy = 0;
          end
        end
      end else if (!mem_busy) begin
        m_out = 1;
      end
    end else if (req_valid && !exp_hit && !flush) begin
      m_valid[ri] = 0;
      m_busy  = 1;
      m_out   = 0;
      m_base  = line_of(req_addr) * 4 * LW;
      m_words = 0;
    end
    if (flush) for (int i = 0; i < LINES; i++) m_valid[i] = 0;
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // Present an address until it hits (bounded); ok reports whether it did.
  task automatic fill(input logic [31:0] a, output bit ok);
    req_valid = 1'b1;
    req_addr  = a;
    ok = 0;
    for (int i = 0; i < 100 && !ok; i++) begin
      step();
      if (o_hit) ok = 1;
    end
    req_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; req_valid = 1'b1; req_addr = 32'h1004; flush = 1'b0;
    mem_busy = 1'b0; mem_rdy = 1'b0; mem_data = 32'h0;
    model_reset();
    #2;
    checks += 6;
    if (hit !== 1'b0)      begin errors++; $display("FAIL reset_hit got=%b exp=0", hit); end
    if (inst !== 32'h0)    begin errors++; $display("FAIL reset_inst got=%h exp=0", inst); end
    if (stall !== 1'b1)    begin errors++; $display("FAIL reset_stall got=%b exp=1", stall); end
    if (mem_req !== 1'b0)  begin errors++; $display("FAIL reset_mem_req got=%b exp=0", mem_req); end
    if (mem_addr !== 32'h0) begin errors++; $display("FAIL reset_mem_addr got=%h exp=0", mem_addr); end
    req_valid = 1'b0;
    #1;
    if (stall !== 1'b0)    begin errors++; $display("FAIL reset_stall_idle got=%b exp=0", stall); end
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_cold_miss();
    int req_cyc[$];
    logic [31:0] req_adr[$];
    int first_hit = -1;
    logic [31:0] hit_inst = 32'h0;
    lat = 2; rand_lat = 0;
    req_valid = 1'b1; req_addr = 32'h1004;
    for (int c = 0; c <= 13; c++) begin
      step();
      if (o_req) begin req_cyc.push_back(c); req_adr.push_back(o_addr); end
      if (o_hit && first_hit < 0) begin first_hit = c; hit_inst = o_inst; end
    end
    checks++;
    if (req_cyc.size() != 4) begin
      errors++; $display("FAIL cold_req_count got=%0d exp=4", req_cyc.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        checks += 2;
        if (req_cyc[i] != 1 + 3 * i) begin
          errors++; $display("FAIL cold_req_cycle[%0d] got=%0d exp=%0d", i, req_cyc[i], 1 + 3 * i);
        end
        if (req_adr[i] !== 32'h1000 + 4 * i) begin
          errors++; $display("FAIL cold_req_addr[%0d] got=%h exp=%h", i, req_adr[i], 32'h1000 + 4 * i);
        end
      end
    end
    checks += 2;
    if (first_hit != 13) begin errors++; $display("FAIL cold_hit_cycle got=%0d exp=13", first_hit); end
    if (hit_inst !== mem_word(32'h1004)) begin
      errors++; $display("FAIL cold_hit_inst got=%h exp=%h", hit_inst, mem_word(32'h1004));
    end
    req_addr = 32'h100C;
    step();
    checks += 2;
    if (o_hit !== 1'b1) begin errors++; $display("FAIL same_line_hit got=%b exp=1", o_hit); end
    if (o_inst !== mem_word(32'h100C)) begin
      errors++; $display("FAIL same_line_inst got=%h exp=%h", o_inst, mem_word(32'h100C));
    end
    req_valid = 1'b0;
  endtask

  task automatic test_conflict();
    bit ok;
    req_valid = 1'b1; req_addr = 32'h2000;
    step();
    checks++;
    if (o_hit !== 1'b0) begin errors++; $display("FAIL conflict_miss got=%b exp=0", o_hit); end
    fill(32'h2000, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL conflict_fill got=timeout exp=hit"); end
    req_valid = 1'b1; req_addr = 32'h1000;
    step();
    checks++;
    if (o_hit !== 1'b0) begin errors++; $display("FAIL conflict_evicted got=%b exp=0", o_hit); end
    fill(32'h1000, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL refill_1000 got=timeout exp=hit"); end
  endtask

  task automatic test_hit_under_refill();
    bit ok;
    int r0 = req_count;
    req_valid = 1'b1; req_addr = 32'h2040;
    step();
    req_addr = 32'h1008;
    for (int i = 0; i < 6; i++) begin
      step();
      checks += 2;
      if (o_hit !== 1'b1) begin errors++; $display("FAIL hur_hit[%0d] got=%b exp=1", i, o_hit); end
      if (o_inst !== mem_word(32'h1008)) begin
        errors++; $display("FAIL hur_inst[%0d] got=%h exp=%h", i, o_inst, mem_word(32'h1008));
      end
    end
    fill(32'h2040, ok);
    checks += 2;
    if (!ok) begin errors++; $display("FAIL hur_fill got=timeout exp=hit"); end
    if (req_count - r0 != 4) begin
      errors++; $display("FAIL hur_req_count got=%0d exp=4", req_count - r0);
    end
  endtask

  task automatic test_busy();
    bit ok;
    int r0 = req_count;
    req_valid = 1'b1; req_addr = 32'h3000;
    step();
    req_valid = 1'b0;
    mem_busy  = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (o_req !== 1'b0) begin errors++; $display("FAIL busy_hold[%0d] got=%b exp=0", i, o_req); end
    end
    mem_busy = 1'b0;
    step();
    checks += 2;
    if (o_req !== 1'b1) begin errors++; $display("FAIL busy_release got=%b exp=1", o_req); end
    if (o_addr !== 32'h3000) begin errors++; $display("FAIL busy_addr got=%h exp=3000", o_addr); end
    fill(32'h3000, ok);
    checks += 2;
    if (!ok) begin errors++; $display("FAIL busy_fill got=timeout exp=hit"); end
    if (req_count - r0 != 4) begin
      errors++; $display("FAIL busy_req_count got=%0d exp=4", req_count - r0);
    end
  endtask

  task automatic test_flush();
    bit ok;
    int r0 = req_count;
    int guard = 0;
    req_valid = 1'b1; req_addr = 32'h1000;
    step();
    req_valid = 1'b0;
    while (req_count - r0 < 3 && guard < 40) begin step(); guard++; end
    checks++;
    if (req_count - r0 != 3) begin
      errors++; $display("FAIL flush_reach_word2 got=%0d exp=3", req_count - r0);
    end
    flush = 1'b1;
    step();
    flush = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      checks++;
      if (o_req !== 1'b0) begin errors++; $display("FAIL flush_no_req[%0d] got=%b exp=0", i, o_req); end
    end
    req_valid = 1'b1; req_addr = 32'h2040; flush = 1'b1;
    step();
    checks++;
    if (o_hit !== 1'b0) begin errors++; $display("FAIL flush_with_miss_hit got=%b exp=0", o_hit); end
    req_valid = 1'b0; flush = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (o_req !== 1'b0) begin errors++; $display("FAIL flush_miss_no_req[%0d] got=%b exp=0", i, o_req); end
    end
    req_valid = 1'b1; req_addr = 32'h3000;
    step();
    checks++;
    if (o_hit !== 1'b0) begin errors++; $display("FAIL flushed_line_miss got=%b exp=0", o_hit); end
    req_valid = 1'b0;
    step();
    checks++;
    if (o_req !== 1'b1) begin errors++; $display("FAIL post_flush_refill got=%b exp=1", o_req); end
    fill(32'h3000, ok);
  endtask

  task automatic test_async_reset();
    bit ok;
    fill(32'h2040, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL ar_prefill got=timeout exp=hit"); end
    req_valid = 1'b1; req_addr = 32'h1000;
    step();
    req_valid = 1'b0;
    step();
    checks++;
    if (o_req !== 1'b1) begin errors++; $display("FAIL ar_issue got=%b exp=1", o_req); end
    // now inside the first WAIT cycle
    req_valid = 1'b1; req_addr = 32'h2040; mem_rdy = 1'b0;
    #2;
    checks++;
    if (hit !== 1'b1) begin errors++; $display("FAIL ar_pre_hit got=%b exp=1", hit); end
    rst = 1'b1;
    #1;
    checks += 4;
    if (hit !== 1'b0)     begin errors++; $display("FAIL ar_hit got=%b exp=0", hit); end
    if (inst !== 32'h0)   begin errors++; $display("FAIL ar_inst got=%h exp=0", inst); end
    if (mem_req !== 1'b0) begin errors++; $display("FAIL ar_mem_req got=%b exp=0", mem_req); end
    if (stall !== 1'b1)   begin errors++; $display("FAIL ar_stall got=%b exp=1", stall); end
    @(posedge clk);
    #2;
    rst = 1'b0;
    model_reset();
    req_addr = 32'h1000;
    step();
    checks++;
    if (o_hit !== 1'b0) begin errors++; $display("FAIL ar_post_miss got=%b exp=0", o_hit); end
    req_valid = 1'b0;
    step();
    checks += 2;
    if (o_req !== 1'b1) begin errors++; $display("FAIL ar_post_req got=%b exp=1", o_req); end
    if (o_addr !== 32'h1000) begin errors++; $display("FAIL ar_post_addr got=%h exp=1000", o_addr); end
    fill(32'h1000, ok);
  endtask

  task automatic test_random();
    int h0 = hit_count;
    rand_lat = 1;
    for (int i = 0; i < 1500; i++) begin
      req_valid = ($urandom_range(0, 9) < 8);
      req_addr  = ($urandom_range(0, 3) << 10) | ($urandom_range(0, 7) << 4)
                | ($urandom_range(0, 3) << 2);
      flush     = ($urandom_range(0, 49) == 0);
      mem_busy  = ($urandom_range(0, 3) == 0);
      step();
    end
    flush = 1'b0; mem_busy = 1'b0; req_valid = 1'b0;
    checks++;
    if (hit_count - h0 < 50) begin
      errors++; $display("FAIL random_hits got=%0d exp>=50", hit_count - h0);
    end
  endtask

  initial begin
    test_reset();
    test_cold_miss();
    test_conflict();
    test_hit_under_refill();
    test_busy();
    test_flush();
    test_async_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/icache.md
# icache

Parametrised direct-mapped instruction cache with multi-word lines, a line-refill state machine toward mem_ctrl, whole-cache flush and hit-under-refill. It sits between the IF stage (lookup side) and mem_ctrl (refill side). It replaces the single-word cache embedded in IF with full-tag compare, configurable geometry and abortable refills.

## Interface
- ADDR_W, 32, address width in bits
- LINES, 64, number of cache lines (power of 2, ≥2)
- LINE_WORDS, 4, 32-bit words per line (power of 2, ≥1)
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- req_valid  in  1  IF requests the instruction at req_addr this cycle
- req_addr  in  ADDR_W  fetch address, word-aligned (bits [1:0] ignored)
- flush  in  1  invalidate all lines (fence.i) and abort any refill
- hit  out  1  inst valid this cycle (combinational)
- inst  out  32  instruction word; 0 when hit=0
- stall  out  1  req_valid && !hit
- mem_req  out  1  one-cycle word-read request
- mem_addr  out  ADDR_W  word address of mem_req; 0 when mem_req=0
- mem_busy  in  1  mem_ctrl cannot accept a request
- mem_rdy  in  1  one-cycle pulse, mem_data valid
- mem_data  in  32  returned word

## Operation
- Address split: OFF = log2(LINE_WORDS) bits at [OFF+1:2]; IDX = log2(LINES) bits above; TAG = remaining ADDR_W−2−OFF−IDX upper bits. Full tag compared.
- Storage: data[LINES][LINE_WORDS], tag[LINES], valid[LINES].
- hit = req_valid && !flush && valid[idx] && tag[idx]==req_tag. Evaluated in every state (hit-under-refill for other lines).
- State machine, states IDLE, ISSUE, WAIT, DRAIN:
  - IDLE: req_valid && !hit && !flush → latch base = req_addr with offset and bits [1:0] zeroed, cnt=0, clear valid[idx], go ISSUE.
  - ISSUE: flush → IDLE. Else if !mem_busy: mem_req=1, mem_addr=base+4·cnt, go WAIT. Else hold.
  - WAIT: flush → DRAIN (or IDLE if mem_rdy same cycle, word discarded). mem_rdy → data[line][cnt]=mem_data; if cnt==LINE_WORDS−1, write tag, set valid, go IDLE; else cnt+1, go ISSUE.
  - DRAIN: mem_rdy → discard, IDLE. No mem_req issued.
- Refill always runs from word 0 to completion unless flushed; a change of req_addr mid-refill does not abort it.
- A miss to a different line during refill stalls until IDLE, then starts its own refill.
- flush: at the next edge all valid bits clear. flush and a miss in the same cycle: flush wins, no refill starts. flush during DRAIN has no further effect.
- Reset (async): state IDLE, cnt 0, all valid 0, mem_req 0, base 0. Data/tag arrays need not be cleared. mem_ctrl shares rst, so no drain is needed after reset.

## Timing
- Hit: zero-cycle; inst the same cycle req_addr is presented.
- Miss detected in cycle 0 (IDLE). First mem_req in cycle 1 if mem_busy=0.
- With mem_ctrl latency L (mem_rdy L cycles after mem_req), each word costs L+1 cycles. Final mem_rdy in cycle LINE_WORDS·(L+1).
- Line is valid and hit=1 the cycle after the final mem_rdy (cycle LINE_WORDS·(L+1)+1), provided req_addr still maps to it.
- mem_req is never high on two consecutive cycles. At most one request is outstanding.
- Cycles with mem_busy=1 in ISSUE add one cycle each.
- Reset outputs: hit 0, inst 0, stall = req_valid, mem_req 0, mem_addr 0.

## Test plan
- Cold miss, defaults, L=2, req_addr=0x1004: mem_req in cycles 1,4,7,10 with mem_addr 0x1000,0x1004,0x1008,0x100C; hit=1 in cycle 13 with inst = word returned for 0x1004. Then 0x100C hits in 0 cycles.
- Conflict: fill 0x1000, then request 0x2000 (same index, different tag) → miss and refill; 0x1000 then misses again.
- Hit-under-refill: line 0x1000 valid; start refill of 0x2040; during WAIT present 0x1008 → hit=1 immediately, refill proceeds unaffected.
- mem_busy held for 3 cycles in ISSUE → mem_req delayed exactly 3 cycles, address unchanged, no duplicate request.
- flush in WAIT at word 2: mem_rdy for word 2 discarded, state IDLE, no further mem_req; all previously valid lines miss; a flush asserted together with a miss launches no refill.
- Async rst asserted mid-WAIT, between clock edges → mem_req 0 and hit 0 immediately; after release, 0x1000 misses.
